link_arbiter: RTL and testbench

LINK_ARBITER -- requirements
Module: link_arbiter

---
 rtl/link_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_link_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_arbiter.sv
// Round-robin arbiter giving four requesters turns on one transceiver, plus a single-entry
// receive buffer with sticky overrun. Define TX_TIMEOUT_EN to abort frames stuck in BUSY.
`ifndef FRAME_SIZE
`define FRAME_SIZE 8
`endif

module link_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               req,
  input  logic [4*`FRAME_SIZE-1:0] req_data,
  output logic [3:0]               grant,
  output logic [3:0]               done,
  output logic                     tx_enable,
  output logic [`FRAME_SIZE-1:0]   tx_data,
  input  logic                     irq_tx,
  input  logic                     irq_rx,
  input  logic [`FRAME_SIZE-1:0]   rx_data,
  output logic [`FRAME_SIZE-1:0]   rx_frame,
  output logic                     rx_valid,
  input  logic                     rx_ack,
  output logic                     rx_overrun,
  output logic                     tx_timeout,
  output logic [15:0]              tx_count
);
  localparam int FS = `FRAME_SIZE;

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    owner_q, owner_d;
  logic [3:0]    grant_q, grant_d;
  logic [3:0]    done_q, done_d;
  logic          tx_enable_q, tx_enable_d;
  logic [FS-1:0] tx_data_q, tx_data_d;
  logic [15:0]   tx_count_q, tx_count_d;
  logic          tx_timeout_q, tx_timeout_d;
  logic          timeout_hit;
  logic [FS-1:0] rx_frame_q, rx_frame_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_overrun_q, rx_overrun_d;

  logic [FS-1:0] frame [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_slice
    assign frame[gi] = req_data[gi*FS +: FS];
  end

  // First requesting index found scanning upward from ptr, wrapping mod 4.
  logic       found;
  logic [1:0] pick;
  logic [1:0] idx;
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == START) begin
      tmo_cnt_d = '0;
    end else if (state_q == BUSY) begin
      tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
    end
  end

  // Fires in the last permitted BUSY cycle so DONE lands TIMEOUT_CYCLES BUSY cycles after START.
  assign timeout_hit = (state_q == BUSY) && (tmo_cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == TIMEOUT_W);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    done_d       = '0;
    tx_enable_d  = 1'b0;
    tx_data_d    = tx_data_q;
    tx_count_d   = tx_count_q;
    tx_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = START;
          owner_d     = pick;
          grant_d     = 4'b0001 << pick;
          tx_data_d   = frame[pick];
          tx_enable_d = 1'b1;
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (irq_tx || timeout_hit) begin
          state_d      = DONE;
          done_d       = grant_q;
          tx_timeout_d = !irq_tx;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = owner_q + 2'd1;
        // An aborted frame is not a completed one.
        if (!tx_timeout_q) begin
          tx_count_d = tx_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_frame_d   = rx_frame_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    if (irq_rx) begin
      if (!rx_valid_q || rx_ack) begin
        rx_frame_d = rx_data;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      tx_enable_q  <= 1'b0;
      tx_data_q    <= '0;
      tx_count_q   <= '0;
      tx_timeout_q <= 1'b0;
      rx_frame_q   <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      tx_enable_q  <= tx_enable_d;
      tx_data_q    <= tx_data_d;
      tx_count_q   <= tx_count_d;
      tx_timeout_q <= tx_timeout_d;
      rx_frame_q   <= rx_frame_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign tx_enable  = tx_enable_q;
  assign tx_data    = tx_data_q;
  assign tx_count   = tx_count_q;
  assign tx_timeout = tx_timeout_q;
  assign rx_frame   = rx_frame_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_link_arbiter.sv
// Self-checking bench for link_arbiter: expected frames go into a scoreboard queue when
// requests are driven and are popped when tx_enable appears. Outputs sampled at negedge.
`ifndef FRAME_SIZE
`define FRAME_SIZE 8
`endif

module tb_link_arbiter;
  localparam int FS = `FRAME_SIZE;

  logic            clock = 1'b0;
  logic            reset;
  logic [3:0]      req;
  logic [4*FS-1:0] req_data;
  logic [3:0]      grant;
  logic [3:0]      done;
  logic            tx_enable;
  logic [FS-1:0]   tx_data;
  logic            irq_tx;
  logic            irq_rx;
  logic [FS-1:0]   rx_data;
  logic [FS-1:0]   rx_frame;
  logic            rx_valid;
  logic            rx_ack;
  logic            rx_overrun;
  logic            tx_timeout;
  logic [15:0]     tx_count;

  typedef struct packed {
    logic [3:0]    g;
    logic [FS-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   exp_count;

  always #5 clock = ~clock;

  link_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_W(16)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .tx_enable(tx_enable), .tx_data(tx_data),
    .irq_tx(irq_tx), .irq_rx(irq_rx), .rx_data(rx_data), .rx_frame(rx_frame),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .rx_overrun(rx_overrun),
    .tx_timeout(tx_timeout), .tx_count(tx_count)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_slot(input int i, input logic [FS-1:0] v);
    req_data[i*FS +: FS] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; irq_tx = 1'b1; irq_rx = 1'b1; rx_data = 8'hFF; rx_ack = 1'b0;
    req_data = '1;
    tick(); tick();
    checks++;
    if ({grant, done, tx_enable, tx_timeout, rx_valid, rx_overrun} !== 12'h000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0", {grant, done, tx_enable, tx_timeout, rx_valid, rx_overrun});
    end
    checks++;
    if (tx_data !== '0 || rx_frame !== '0 || tx_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: tx_data=%h rx_frame=%h tx_count=%0d required 0", tx_data, rx_frame, tx_count);
    end
    reset = 1'b0; req = '0; irq_tx = 1'b0; irq_rx = 1'b0; rx_data = '0; req_data = '0;
  endtask

  task automatic test_single();
    exp_t e;
    set_slot(0, 8'h11); set_slot(1, 8'hA5); set_slot(2, 8'h22); set_slot(3, 8'h33);
    req = 4'b0010;
    exp_q.push_back('{g: 4'b0010, d: 8'hA5});
    tick();
    checks++;
    if (tx_enable !== 1'b1) begin errors++; $display("FAIL single_tx_enable: got %b required 1", tx_enable); end
    checks++;
    if (exp_q.size() == 0) begin errors++; e = '0; $display("FAIL single_sb: got empty queue required entry"); end
    else e = exp_q.pop_front();
    checks++;
    if (grant !== e.g || tx_data !== e.d) begin
      errors++; $display("FAIL single_start: got grant=%b data=%h required grant=%b data=%h", grant, tx_data, e.g, e.d);
    end
    $display("frame start grant=%b data=%h", grant, tx_data);
    set_slot(1, 8'h5A);
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if (tx_enable !== 1'b0 || done !== 4'b0000 || grant !== 4'b0010) begin
        errors++; $display("FAIL single_busy%0d: got en=%b done=%b grant=%b required 0/0000/0010", c, tx_enable, done, grant);
      end
      if (c == 10) irq_tx = 1'b1;
    end
    tick();
    checks++;
    if (done !== 4'b0010 || tx_timeout !== 1'b0) begin
      errors++; $display("FAIL single_done: got done=%b tmo=%b required 0010/0", done, tx_timeout);
    end
    checks++;
    if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data_hold: got %h required a5", tx_data); end
    irq_tx = 1'b0; req = '0; exp_count++;
    tick();
    checks++;
    if (done !== 4'b0000 || grant !== 4'b0000 || tx_count !== 16'(exp_count)) begin
      errors++; $display("FAIL single_after: got done=%b grant=%b count=%0d required 0000/0000/%0d", done, grant, tx_count, exp_count);
    end
  endtask

  task automatic test_irq_ignored();
    exp_t e;
    irq_tx = 1'b1;
    tick(); tick();
    checks++;
    if (done !== 4'b0000 || grant !== 4'b0000 || tx_count !== 16'(exp_count)) begin
      errors++; $display("FAIL idle_irq: got done=%b grant=%b count=%0d required 0000/0000/%0d", done, grant, tx_count, exp_count);
    end
    req = 4'b0100; set_slot(2, 8'hC7);
    exp_q.push_back('{g: 4'b0100, d: 8'hC7});
    tick();
    checks++;
    if (exp_q.size() == 0) begin errors++; e = '0; $display("FAIL irq_sb: got empty queue required entry"); end
    else e = exp_q.pop_front();
    checks++;
    if (tx_enable !== 1'b1 || grant !== e.g || tx_data !== e.d) begin
      errors++; $display("FAIL irq_start: got en=%b grant=%b data=%h required 1/%b/%h", tx_enable, grant, tx_data, e.g, e.d);
    end
    $display("frame start grant=%b data=%h", grant, tx_data);
    tick();
    checks++;
    if (done !== 4'b0000 || grant !== 4'b0100) begin
      errors++; $display("FAIL start_irq: got done=%b grant=%b required 0000/0100", done, grant);
    end
    irq_tx = 1'b0;
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (done !== 4'b0000 || grant !== 4'b0100) begin
      errors++; $display("FAIL req_drop: got done=%b grant=%b required 0000/0100", done, grant);
    end
    irq_tx = 1'b1;
    tick();
    checks++;
    if (done !== 4'b0100) begin errors++; $display("FAIL drop_done: got %b required 0100", done); end
    exp_count++;
    tick();
    checks++;
    if (done !== 4'b0000 || grant !== 4'b0000) begin
      errors++; $display("FAIL done_irq: got done=%b grant=%b required 0000/0000", done, grant);
    end
    irq_tx = 1'b0;
    tick();
    checks++;
    if (done !== 4'b0000 || tx_count !== 16'(exp_count)) begin
      errors++; $display("FAIL irq_count: got done=%b count=%0d required 0000/%0d", done, tx_count, exp_count);
    end
  endtask

  task automatic test_rx();
    irq_rx = 1'b1; rx_data = 8'h3C;
    tick();
    checks++;
    if (rx_valid !== 1'b1 || rx_frame !== 8'h3C || rx_overrun !== 1'b0) begin
      errors++; $display("FAIL rx_load: got v=%b f=%h o=%b required 1/3c/0", rx_valid, rx_frame, rx_overrun);
    end
    rx_data = 8'h5A;
    tick();
    checks++;
    if (rx_valid !== 1'b1 || rx_frame !== 8'h3C || rx_overrun !== 1'b1) begin
      errors++; $display("FAIL rx_overrun: got v=%b f=%h o=%b required 1/3c/1", rx_valid, rx_frame, rx_overrun);
    end
    rx_data = 8'h77; rx_ack = 1'b1;
    tick();
    checks++;
    if (rx_valid !== 1'b1 || rx_frame !== 8'h77 || rx_overrun !== 1'b1) begin
      errors++; $display("FAIL rx_ack_load: got v=%b f=%h o=%b required 1/77/1", rx_valid, rx_frame, rx_overrun);
    end
    irq_rx = 1'b0;
    tick();
    checks++;
    if (rx_valid !== 1'b0 || rx_frame !== 8'h77 || rx_overrun !== 1'b1) begin
      errors++; $display("FAIL rx_consume: got v=%b f=%h o=%b required 0/77/1", rx_valid, rx_frame, rx_overrun);
    end
    tick();
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_idle_ack: got %b required 0", rx_valid); end
    rx_ack = 1'b0; irq_rx = 1'b1; rx_data = 8'hC3;
    tick();
    irq_rx = 1'b0;
    tick();
    checks++;
    if (rx_valid !== 1'b1 || rx_frame !== 8'hC3) begin
      errors++; $display("FAIL rx_reload: got v=%b f=%h required 1/c3", rx_valid, rx_frame);
    end
    $display("rx frame=%h overrun=%b", rx_frame, rx_overrun);
  endtask

  task automatic test_round_robin();
    exp_t e;
    reset = 1'b1;
    tick();
    reset = 1'b0; exp_count = 0;
    for (int i = 0; i < 4; i++) set_slot(i, 8'(8'h40 + i));
    for (int f = 0; f < 5; f++) exp_q.push_back('{g: 4'b0001 << (f % 4), d: 8'(8'h40 + (f % 4))});
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      tick();
      checks++;
      if (exp_q.size() == 0) begin errors++; e = '0; $display("FAIL rr_sb%0d: got empty queue required entry", f); end
      else e = exp_q.pop_front();
      checks++;
      if (tx_enable !== 1'b1 || grant !== e.g || tx_data !== e.d) begin
        errors++; $display("FAIL rr_start%0d: got en=%b grant=%b data=%h required 1/%b/%h", f, tx_enable, grant, tx_data, e.g, e.d);
      end
      $display("frame start grant=%b data=%h", grant, tx_data);
      tick();
      irq_tx = 1'b1;
      tick();
      checks++;
      if (done !== e.g) begin errors++; $display("FAIL rr_done%0d: got %b required %b", f, done, e.g); end
      irq_tx = 1'b0; exp_count++;
      if (f == 4) req = 4'b0000;
      tick();
      checks++;
      if (grant !== 4'b0000 || tx_enable !== 1'b0) begin
        errors++; $display("FAIL rr_gap%0d: got grant=%b en=%b required 0000/0", f, grant, tx_enable);
      end
    end
    checks++;
    if (tx_count !== 16'(exp_count)) begin errors++; $display("FAIL rr_count: got %0d required %0d", tx_count, exp_count); end
  endtask

  task automatic test_reset_mid_frame();
    exp_t e;
    req = 4'b0001; set_slot(0, 8'h99); irq_rx = 1'b1; rx_data = 8'h5E;
    exp_q.push_back('{g: 4'b0001, d: 8'h99});
    tick();
    irq_rx = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin errors++; e = '0; $display("FAIL rst_sb: got empty queue required entry"); end
    else e = exp_q.pop_front();
    checks++;
    if (tx_enable !== 1'b1 || grant !== e.g || tx_data !== e.d) begin
      errors++; $display("FAIL rst_start: got en=%b grant=%b data=%h required 1/%b/%h", tx_enable, grant, tx_data, e.g, e.d);
    end
    $display("frame start grant=%b data=%h", grant, tx_data);
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({grant, done, tx_enable, tx_timeout, rx_valid, rx_overrun} !== 12'h000) begin
      errors++; $display("FAIL rst_ctrl: got %b required 0", {grant, done, tx_enable, tx_timeout, rx_valid, rx_overrun});
    end
    checks++;
    if (tx_data !== '0 || rx_frame !== '0 || tx_count !== 16'd0) begin
      errors++; $display("FAIL rst_data: tx_data=%h rx_frame=%h count=%0d required 0", tx_data, rx_frame, tx_count);
    end
    reset = 1'b0; exp_count = 0;
    exp_q.push_back('{g: 4'b0001, d: 8'h99});
    tick();
    checks++;
    if (exp_q.size() == 0) begin errors++; e = '0; $display("FAIL rst_sb2: got empty queue required entry"); end
    else e = exp_q.pop_front();
    checks++;
    if (tx_enable !== 1'b1 || grant !== e.g || tx_data !== e.d) begin
      errors++; $display("FAIL rst_restart: got en=%b grant=%b data=%h required 1/%b/%h", tx_enable, grant, tx_data, e.g, e.d);
    end
    $display("frame start grant=%b data=%h", grant, tx_data);
    tick();
    irq_tx = 1'b1;
    tick();
    checks++;
    if (done !== 4'b0001) begin errors++; $display("FAIL rst_done: got %b required 0001", done); end
    irq_tx = 1'b0; req = 4'b0000; exp_count++;
    tick();
    checks++;
    if (tx_count !== 16'(exp_count)) begin errors++; $display("FAIL rst_count: got %0d required %0d", tx_count, exp_count); end
  endtask

  task automatic test_timeout();
    exp_t e;
    req = 4'b0010; set_slot(1, 8'h6B);
    exp_q.push_back('{g: 4'b0010, d: 8'h6B});
    tick();
    checks++;
    if (exp_q.size() == 0) begin errors++; e = '0; $display("FAIL tmo_sb: got empty queue required entry"); end
    else e = exp_q.pop_front();
    checks++;
    if (tx_enable !== 1'b1 || grant !== e.g || tx_data !== e.d) begin
      errors++; $display("FAIL tmo_start: got en=%b grant=%b data=%h required 1/%b/%h", tx_enable, grant, tx_data, e.g, e.d);
    end
    $display("frame start grant=%b data=%h", grant, tx_data);
`ifdef TX_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (done !== 4'b0000 || tx_timeout !== 1'b0) begin
        errors++; $display("FAIL tmo_wait%0d: got done=%b tmo=%b required 0000/0", c, done, tx_timeout);
      end
    end
    tick();
    checks++;
    if (done !== 4'b0010 || tx_timeout !== 1'b1) begin
      errors++; $display("FAIL tmo_abort: got done=%b tmo=%b required 0010/1", done, tx_timeout);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (done !== 4'b0000 || tx_timeout !== 1'b0 || tx_count !== 16'(exp_count)) begin
      errors++; $display("FAIL tmo_after: got done=%b tmo=%b count=%0d required 0000/0/%0d", done, tx_timeout, tx_count, exp_count);
    end
`else
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (done !== 4'b0000 || grant !== 4'b0010 || tx_timeout !== 1'b0) begin
        errors++; $display("FAIL busy_wait%0d: got done=%b grant=%b tmo=%b required 0000/0010/0", c, done, grant, tx_timeout);
      end
    end
    irq_tx = 1'b1;
    tick();
    checks++;
    if (done !== 4'b0010 || tx_timeout !== 1'b0) begin
      errors++; $display("FAIL busy_done: got done=%b tmo=%b required 0010/0", done, tx_timeout);
    end
    irq_tx = 1'b0; req = 4'b0000; exp_count++;
    tick();
    checks++;
    if (tx_count !== 16'(exp_count)) begin errors++; $display("FAIL busy_count: got %0d required %0d", tx_count, exp_count); end
`endif
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; irq_tx = 1'b0; irq_rx = 1'b0; rx_data = '0; rx_ack = 1'b0;
    checks = 0; errors = 0; exp_count = 0;
    test_reset();
    test_single();
    test_irq_ignored();
    test_rx();
    test_round_robin();
    test_reset_mid_frame();
    test_timeout();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
